seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
// - Time-multiplexes NUM_DIGITS BCD digits onto one shared BCD-to-7-segment decoder and a common-cathode/anode display.
// - Drives the decoder BCD input plus one enable per digit.
// - Digit values are written through a valid/ready port into a shadow bank.
// - The shadow bank is copied to the active bank only at a frame boundary, so the display never tears.
// - Sits between CPU-side display registers and the board's seven-segment decoder and digit enables.
// PARAMETERS
// - NUM_DIGITS    4      number of multiplexed digits (2..8)
// - CLK_DIV       50000  clocks each digit is lit (>=2)
// - BLANK_CYCLES  8      dead-time clocks with all digits off between digits (>=1)
// - EN_ACTIVE_LOW 1      1: digit_en active-low; 0: active-high
// PORTS
// - clk         in   1        system clock, rising edge
// - reset       in   1        asynchronous, active-low reset
// - wr_valid    in   1        digit write request
// - wr_ready    out  1        write can be accepted this cycle
// - wr_digit    in   DW       digit index, DW=$clog2(NUM_DIGITS)
// - wr_value    in   4        BCD/hex value, 0..15
// - commit      in   1        1-clk pulse: copy shadow bank to active bank at next frame boundary
// - bcd_out     out  4        value to the shared decoder (registered)
// - digit_en    out  NUM_DIGITS  one-hot digit enable (polarity per EN_ACTIVE_LOW)
// - frame_start out  1        1-clk pulse on entry to DISPLAY of digit 0
// BEHAVIOUR
// - Reset values (async): state=BLANK, idx=0, counter=0, shadow=active=0, pending=0, bcd_out=0, digit_en=all inactive, wr_ready=1, frame_start=0.
// - FSM states:
//   - BLANK: all digit_en inactive for BLANK_CYCLES clks, then go to DISPLAY.
//   - DISPLAY: digit_en[idx] active and bcd_out=active[idx] for CLK_DIV clks, then go to BLANK with idx=idx+1; idx wraps NUM_DIGITS-1 -> 0.
// - Frame boundary: the BLANK->DISPLAY transition with idx==0.
//   - frame_start pulses in the first DISPLAY cycle of digit 0.
// - bcd_out updates on the same edge that enters DISPLAY; it holds its value through BLANK.
// - Write handshake:
//   - A write is accepted when wr_valid && wr_ready: shadow[wr_digit] <= wr_value on that edge.
//   - If wr_digit >= NUM_DIGITS, the write is accepted and dropped.
//   - wr_valid may be held; one write per accepted cycle.
// - Commit:
//   - commit while pending==0 sets pending=1 on the next edge.
//   - wr_ready = !pending (combinational from the pending register).
//   - At the next frame boundary: active <= shadow, pending <= 0, so wr_ready returns to 1 in the following cycle.
//   - commit while pending==1 is ignored.
// - Simultaneous events:
//   - A write accepted in the same cycle as commit is included in the commit.
//   - A commit pulse on the frame-boundary edge itself sets pending and applies at the following frame boundary, not the current one.
// - Reset mid-operation: immediate return to reset values; shadow and active contents are lost.
// - A digit is never lit during BLANK. Two digit_en bits are never active together.
// CONFIGURATION
// - Macro LEADING_ZERO_BLANK_EN.
// - Defined:
//   - In DISPLAY, digit_en[idx] stays inactive when idx > 0 and active[j]==0 for every j>=idx (leading zeros).
//   - Digit 0 is always lit.
//   - Timing and bcd_out are unchanged.
// - Undefined: all digits are lit in turn, including leading zeros.
// STRUCTURE
// - Shared include seven_seg_defs.vh holds:
//   - state encoding localparams ST_BLANK=1'b0, ST_DISPLAY=1'b1;
//   - the DW width function/localparam;
//   - the digit_en polarity helper.
// - Sub-module scan_prescaler: reloadable down-counter.
//   - Loads CLK_DIV-1 or BLANK_CYCLES-1 on each state change.
//   - Asserts a one-cycle done when it reaches 0.
//   - Instanced once.
// - Top level: FSM, idx counter, shadow/active banks, pending flag, output registers.
// TESTING (NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1, EN_ACTIVE_LOW=1)
// - Reset release:
//   - digit_en=4'b1111 for 1 clk, then 4'b1110 with bcd_out=0 and frame_start=1.
//   - Then the sequence 1110,1111,1101,1111,1011,1111,0111 repeats, with each lit phase lasting 4 clks.
// - Writes then commit:
//   - Write 1,2,3,4 to digits 0..3, then commit; wr_ready=0 until the next frame_start.
//   - From that frame, bcd_out reads 1,2,3,4 in digit order.
// - Stall:
//   - Hold wr_valid with digit 2 / value 9 while pending.
//   - The write is accepted only on the first cycle with wr_ready=1; shadow[2]=9; active is unchanged until the next commit.
// - Boundary commit: pulse commit on the frame-boundary edge; the active bank updates at the following frame boundary, about 20 clks later.
// - Out-of-range and reset:
//   - wr_digit=4 is accepted with no bank change.
//   - Asserting reset low mid-DISPLAY forces digit_en=1111 and bcd_out=0 asynchronously.
// - LEADING_ZERO_BLANK_EN: with active={0,0,0,7} (digit 0 = 7), only digit_en=1110 ever lights; without the macro, all four digits light.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// rtl/seven_seg_scan_ctrl_pkg.sv - shared types and helpers for the seven-segment scan controller
// Purpose: state encoding, port/counter width helpers and digit-enable polarity helper.
// Ports: none (package).
package seven_seg_scan_ctrl_pkg;

  typedef enum logic {
    ST_BLANK   = 1'b0,
    ST_DISPLAY = 1'b1
  } scan_state_e;

  // Digit-index width. One extra code point is kept so that index NUM_DIGITS
  // (the first out-of-range index) is always expressible on the write port.
  function automatic int dw_f(input int num_digits);
    return $clog2(num_digits + 1);
  endfunction

  // Prescaler width: large enough for the longer of the two phase reloads.
  function automatic int cw_f(input int clk_div, input int blank_cycles);
    int m;
    m = (clk_div > blank_cycles) ? clk_div : blank_cycles;
    return $clog2(m) + 1;
  endfunction

  // Physical pin level for one digit enable given its logical lit state.
  function automatic logic en_level(input logic lit, input logic active_low);
    return lit ^ active_low;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_scan_prescaler.sv
// rtl/seven_seg_scan_ctrl_scan_prescaler.sv - reloadable down-counter timing the scan phases
// Purpose: counts down from a loaded value; o_done is high while the count is zero.
// Ports:
//   i_clk, i_reset_n  clock and asynchronous active-low reset
//   i_load            load i_load_val this edge (issued on every phase change)
//   i_load_val        reload value (phase length minus one)
//   o_done            count has reached zero; high for exactly one cycle per phase
module seven_seg_scan_ctrl_scan_prescaler #(
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_done
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed seven-segment scan controller with shadow/active banks
// Purpose: scans NUM_DIGITS BCD digits onto one shared decoder with dead time between digits;
//   writes land in a shadow bank that is copied to the active bank only at a frame boundary.
// Optional macro LEADING_ZERO_BLANK_EN: leading-zero digits are not lit (digit 0 always lit).
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   wr_valid, wr_ready  digit write handshake (wr_ready = no commit pending)
//   wr_digit, wr_value  target digit index and 4-bit value
//   commit              request a shadow->active copy at the next frame boundary
//   bcd_out             registered value to the shared decoder
//   digit_en            one-hot digit enables, polarity per EN_ACTIVE_LOW
//   frame_start         pulse on the first lit cycle of digit 0
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int CLK_DIV       = 50000,
  parameter  int BLANK_CYCLES  = 8,
  parameter  int EN_ACTIVE_LOW = 1,
  localparam int DW            = dw_f(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DW-1:0]         wr_digit,
  input  logic [3:0]            wr_value,
  input  logic                  commit,
  output logic [3:0]            bcd_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_start
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = cw_f(CLK_DIV, BLANK_CYCLES);
  localparam logic EN_LOW = (EN_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{en_level(1'b0, EN_LOW)}};

  scan_state_e           r_state;
  scan_state_e           w_state_nxt;
  logic [IW-1:0]         r_idx;
  logic [3:0]            r_shadow [NUM_DIGITS];
  logic [3:0]            r_active [NUM_DIGITS];
  logic [3:0]            w_bank   [NUM_DIGITS];
  logic                  r_pending;
  logic [3:0]            r_bcd_out;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic                  r_frame_start;
  logic                  w_done;
  logic                  w_load;
  logic [CW-1:0]         w_load_val;
  logic                  w_enter;
  logic                  w_leave;
  logic                  w_apply;
  logic                  w_wr_fire;
  logic [3:0]            w_bank_sel;
  logic                  w_lit;

  seven_seg_scan_ctrl_scan_prescaler #(
    .CW(CW)
  ) u_scan_prescaler (
    .i_clk      (clk),
    .i_reset_n  (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Every phase change reloads the prescaler with the length of the phase being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = CW'(BLANK_CYCLES - 1);
    if (w_done) begin
      w_load = 1'b1;
      if (r_state == ST_BLANK) begin
        w_state_nxt = ST_DISPLAY;
        w_load_val  = CW'(CLK_DIV - 1);
      end else begin
        w_state_nxt = ST_BLANK;
        w_load_val  = CW'(BLANK_CYCLES - 1);
      end
    end
  end

  assign w_enter   = w_done && (r_state == ST_BLANK);
  assign w_leave   = w_done && (r_state == ST_DISPLAY);
  assign w_apply   = w_enter && (r_idx == '0) && r_pending;
  assign wr_ready  = !r_pending;
  assign w_wr_fire = wr_valid && !r_pending;

  // Bank as it will read after this edge: on the committing boundary the
  // first digit must already show the new value, so look through to shadow.
  always_comb begin
    w_bank_sel = 4'h0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      w_bank[j] = w_apply ? r_shadow[j] : r_active[j];
      if (IW'(j) == r_idx) begin
        w_bank_sel = w_bank[j];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit idx is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    w_lit = 1'b1;
    if (r_idx != '0) begin
      w_lit = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if ((IW'(j) >= r_idx) && (w_bank[j] != 4'h0)) begin
          w_lit = 1'b1;
        end
      end
    end
  end
`else
  assign w_lit = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
    end else if (w_leave) begin
      r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // Out-of-range indices match no entry, so such writes complete and are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        r_shadow[j] <= 4'h0;
        r_active[j] <= 4'h0;
      end
    end else begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (w_wr_fire && (wr_digit == DW'(j))) begin
          r_shadow[j] <= wr_value;
        end
      end
      if (w_apply) begin
        for (int j = 0; j < NUM_DIGITS; j++) begin
          r_active[j] <= r_shadow[j];
        end
        r_pending <= 1'b0;
      end else if (commit && !r_pending) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcd_out     <= 4'h0;
      r_digit_en    <= EN_OFF;
      r_frame_start <= 1'b0;
    end else if (w_enter) begin
      r_bcd_out     <= w_bank_sel;
      r_frame_start <= (r_idx == '0);
      for (int j = 0; j < NUM_DIGITS; j++) begin
        r_digit_en[j] <= en_level((IW'(j) == r_idx) && w_lit, EN_LOW);
      end
    end else begin
      r_frame_start <= 1'b0;
      if (w_leave) begin
        r_digit_en <= EN_OFF;
      end
    end
  end

  assign bcd_out     = r_bcd_out;
  assign digit_en    = r_digit_en;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int CD    = 4;
  localparam int BC    = 1;
  localparam int PER   = CD + BC;
  localparam int FRAME = ND * PER;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       wr_valid = 1'b0;
  logic       commit   = 1'b0;
  logic [2:0] wr_digit = 3'd0;
  logic [3:0] wr_value = 4'd0;
  logic       wr_ready;
  logic       frame_start;
  logic [3:0] bcd_out;
  logic [3:0] digit_en;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: timing from edge count since reset release, banks as arrays.
  int         ecount = 0;
  logic [3:0] m_shadow [ND];
  logic [3:0] m_active [ND];
  logic [3:0] m_bcd     = 4'h0;
  logic [3:0] m_en      = 4'hF;
  logic       m_pending = 1'b0;
  logic       m_acc     = 1'b0;
  logic [3:0] cur [ND];
  logic [9:0] got;
  logic [9:0] exp;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS    (ND),
    .CLK_DIV       (CD),
    .BLANK_CYCLES  (BC),
    .EN_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_digit    (wr_digit),
    .wr_value    (wr_value),
    .commit      (commit),
    .bcd_out     (bcd_out),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin : model_blk
    int p;
    int d;
    logic lit;
    logic [3:0] one;
    if (!reset) begin
      ecount    = 0;
      m_pending = 1'b0;
      m_bcd     = 4'h0;
      m_en      = 4'hF;
      m_acc     = 1'b0;
      for (int j = 0; j < ND; j++) begin
        m_shadow[j] = 4'h0;
        m_active[j] = 4'h0;
      end
    end else begin
      ecount++;
      p = (ecount - 1) % PER;
      d = ((ecount - 1) / PER) % ND;
      m_acc = wr_valid && !m_pending;
      if (m_acc && (wr_digit < 3'd4)) m_shadow[wr_digit[1:0]] = wr_value;
      if ((p == 0) && (d == 0) && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end else if (commit && !m_pending) begin
        m_pending = 1'b1;
      end
      if (p == 0) begin
        m_bcd = m_active[d];
        lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0) begin
          lit = 1'b0;
          for (int j = d; j < ND; j++) if (m_active[j] != 4'h0) lit = 1'b1;
        end
`endif
        one  = 4'b0001 << d;
        m_en = lit ? ~one : 4'hF;
      end else if (p == CD) begin
        m_en = 4'hF;
      end
    end
  end

  function automatic logic model_fs();
    return (ecount > 0) && (((ecount - 1) % FRAME) == 0);
  endfunction

  function automatic logic [9:0] model_out();
    return {m_en, m_bcd, model_fs(), ~m_pending};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_valid = 1'b0; commit = 1'b0;
    repeat (2) @(negedge clk);
    got = {digit_en, bcd_out, frame_start, wr_ready};
    n_total++;
    if (got !== {4'hF, 4'h0, 1'b0, 1'b1}) $display("FAIL reset_values got=%h exp=%h", got, {4'hF, 4'h0, 1'b0, 1'b1});
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (digit_en !== 4'hF) $display("FAIL first_blank got=%h exp=f", digit_en);
    else n_pass++;
    tick();
    n_total++;
    if ({digit_en, bcd_out, frame_start} !== {4'hE, 4'h0, 1'b1})
      $display("FAIL first_digit0 got=%h/%h/%b exp=e/0/1", digit_en, bcd_out, frame_start);
    else n_pass++;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      got = {digit_en, bcd_out, frame_start, wr_ready}; exp = model_out(); n_total++;
      if (got !== exp) $display("FAIL reset_scan e=%0d got=%h exp=%h", ecount, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_writes_commit();
    logic [3:0] nv [ND];
    int fs_e;
    int k;
    fs_e = -1;
    for (int d = 0; d < ND; d++) cur[d] = 4'h0;
    for (int d = 0; d < ND; d++) begin
      nv[d] = 4'($urandom_range(1, 15));
      wr_valid = 1'b1; wr_digit = 3'(d); wr_value = nv[d]; commit = (d == ND - 1);
      tick();
      got = {digit_en, bcd_out, frame_start, wr_ready}; exp = model_out(); n_total++;
      if (got !== exp) $display("FAIL write_phase e=%0d got=%h exp=%h", ecount, got, exp);
      else n_pass++;
    end
    wr_valid = 1'b0; commit = 1'b0;
    n_total++;
    if (wr_ready !== 1'b0) $display("FAIL ready_after_commit got=%b exp=0", wr_ready);
    else n_pass++;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      tick();
      got = {digit_en, bcd_out, frame_start, wr_ready}; exp = model_out(); n_total++;
      if (got !== exp) $display("FAIL commit_scan e=%0d got=%h exp=%h", ecount, got, exp);
      else n_pass++;
      if (frame_start && (fs_e < 0)) fs_e = ecount;
      if (((ecount - 1) % PER) == 0) begin
        k = ((ecount - 1) / PER) % ND;
        n_total++;
        if (bcd_out !== ((fs_e >= 0) ? nv[k] : cur[k]))
          $display("FAIL commit_digit d=%0d got=%h exp=%h", k, bcd_out, (fs_e >= 0) ? nv[k] : cur[k]);
        else n_pass++;
      end
    end
    n_total++;
    if (fs_e < 0) $display("FAIL commit_timeout got=none exp=frame_start");
    else n_pass++;
    for (int d = 0; d < ND; d++) cur[d] = nv[d];
  endtask

  task automatic test_stall();
    int acc_e;
    int fs_e;
    int k;
    acc_e = -1; fs_e = -1;
    commit = 1'b1; tick(); commit = 1'b0;
    wr_valid = 1'b1; wr_digit = 3'd2; wr_value = 4'd9;
    for (int i = 0; (i < FRAME + 5) && (acc_e < 0); i++) begin
      tick();
      got = {digit_en, bcd_out, frame_start, wr_ready}; exp = model_out(); n_total++;
      if (got !== exp) $display("FAIL stall_scan e=%0d got=%h exp=%h", ecount, got, exp);
      else n_pass++;
      if (m_acc) acc_e = ecount;
    end
    wr_valid = 1'b0;
    n_total++;
    if (acc_e < 0) $display("FAIL stall_timeout got=none exp=accept");
    else n_pass++;
    commit = 1'b1; tick(); commit = 1'b0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      tick();
      got = {digit_en, bcd_out, frame_start, wr_ready}; exp = model_out(); n_total++;
      if (got !== exp) $display("FAIL stall_commit_scan e=%0d got=%h exp=%h", ecount, got, exp);
      else n_pass++;
      if (frame_start && (fs_e < 0)) fs_e = ecount;
      if (((ecount - 1) % PER) == 0) begin
        k = ((ecount - 1) / PER) % ND;
        if (k == 2) begin
          n_total++;
          if (bcd_out !== ((fs_e >= 0) ? 4'd9 : cur[2]))
            $display("FAIL stall_digit2 got=%h exp=%h", bcd_out, (fs_e >= 0) ? 4'd9 : cur[2]);
          else n_pass++;
        end
      end
    end
    cur[2] = 4'd9;
  endtask

  task automatic test_boundary_commit();
    logic [3:0] nv [ND];
    for (int d = 0; d < ND; d++) begin
      nv[d] = cur[d] ^ 4'($urandom_range(1, 15));
      wr_valid = 1'b1; wr_digit = 3'(d); wr_value = nv[d];
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; (i < FRAME + 1) && ((ecount % FRAME) != 0); i++) tick();
    commit = 1'b1; tick(); commit = 1'b0;
    n_total++;
    if ({frame_start, bcd_out, wr_ready} !== {1'b1, cur[0], 1'b0})
      $display("FAIL boundary_edge got=%b/%h/%b exp=1/%h/0", frame_start, bcd_out, wr_ready, cur[0]);
    else n_pass++;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      got = {digit_en, bcd_out, frame_start, wr_ready}; exp = model_out(); n_total++;
      if (got !== exp) $display("FAIL boundary_scan e=%0d got=%h exp=%h", ecount, got, exp);
      else n_pass++;
    end
    n_total++;
    if ({frame_start, bcd_out, wr_ready} !== {1'b1, nv[0], 1'b1})
      $display("FAIL boundary_apply got=%b/%h/%b exp=1/%h/1", frame_start, bcd_out, wr_ready, nv[0]);
    else n_pass++;
    for (int d = 0; d < ND; d++) cur[d] = nv[d];
  endtask

  task automatic test_out_of_range();
    int k;
    wr_valid = 1'b1; wr_digit = 3'd4; wr_value = 4'($urandom_range(0, 15));
    tick();
    wr_valid = 1'b0; commit = 1'b1; tick(); commit = 1'b0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      tick();
      got = {digit_en, bcd_out, frame_start, wr_ready}; exp = model_out(); n_total++;
      if (got !== exp) $display("FAIL oor_scan e=%0d got=%h exp=%h", ecount, got, exp);
      else n_pass++;
      if (((ecount - 1) % PER) == 0) begin
        k = ((ecount - 1) / PER) % ND;
        n_total++;
        if (bcd_out !== cur[k]) $display("FAIL oor_digit d=%0d got=%h exp=%h", k, bcd_out, cur[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] lit_seen;
    int fs_e;
    lit_seen = 4'h0; fs_e = -1;
    for (int d = 0; d < ND; d++) begin
      wr_valid = 1'b1; wr_digit = 3'(d); wr_value = (d == 0) ? 4'd7 : 4'd0; commit = (d == ND - 1);
      tick();
    end
    wr_valid = 1'b0; commit = 1'b0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      tick();
      got = {digit_en, bcd_out, frame_start, wr_ready}; exp = model_out(); n_total++;
      if (got !== exp) $display("FAIL lz_scan e=%0d got=%h exp=%h", ecount, got, exp);
      else n_pass++;
      if (frame_start && (fs_e < 0)) fs_e = ecount;
      if ((fs_e >= 0) && ((ecount - fs_e) < FRAME)) lit_seen = lit_seen | ~digit_en;
    end
`ifdef LEADING_ZERO_BLANK_EN
    n_total++;
    if (lit_seen !== 4'b0001) $display("FAIL lz_lit_set got=%b exp=0001", lit_seen);
    else n_pass++;
`else
    n_total++;
    if (lit_seen !== 4'b1111) $display("FAIL lz_lit_set got=%b exp=1111", lit_seen);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int waited;
    waited = 0;
    while ((digit_en !== 4'hE) && (waited < 2 * FRAME)) begin
      tick();
      waited++;
    end
    n_total++;
    if (digit_en !== 4'hE) $display("FAIL mid_wait got=%h exp=e", digit_en);
    else n_pass++;
    n_total++;
    if (bcd_out !== 4'd7) $display("FAIL mid_pre_bcd got=%h exp=7", bcd_out);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    got = {digit_en, bcd_out, frame_start, wr_ready}; n_total++;
    if (got !== {4'hF, 4'h0, 1'b0, 1'b1}) $display("FAIL mid_async_reset got=%h exp=%h", got, {4'hF, 4'h0, 1'b0, 1'b1});
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      got = {digit_en, bcd_out, frame_start, wr_ready}; exp = model_out(); n_total++;
      if (got !== exp) $display("FAIL post_reset_scan e=%0d got=%h exp=%h", ecount, got, exp);
      else n_pass++;
      n_total++;
      if (bcd_out !== 4'h0) $display("FAIL post_reset_bcd got=%h exp=0", bcd_out);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_writes_commit();
    test_stall();
    test_boundary_commit();
    test_out_of_range();
    test_leading_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
